// File: rtl/exe_muldiv_unit.sv
// Iterative 32-cycle multiply / signed divide unit for the EXE stage, stalling the pipeline while busy.
// Define MULDIV_REM_EN to also accept REM_CMD (signed remainder, sign follows the dividend).
module exe_muldiv_unit #(
    parameter logic [3:0] MUL_CMD = 4'd11,
    parameter logic [3:0] DIV_CMD = 4'd12,
    parameter logic [3:0] REM_CMD = 4'd13,
    parameter int         ITER    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [4:0]  destIn,
    input  logic        WB_EN_IN,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  dest,
    output logic        WB_EN
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic           is_mul_q, is_mul_d, neg_quo_q, neg_quo_d, div_zero_q, div_zero_d;
    logic [4:0]     dest_hold_q, dest_hold_d, dest_q, dest_d;
    logic           wb_hold_q, wb_hold_d, wb_en_q, wb_en_d, done_q, done_d;
    logic [31:0]    result_q, result_d;
    logic           is_md_s, is_rem_cmd_s, div_ge_s;
    logic [32:0]    rem_sh_s;
    logic [31:0]    mul_acc_s, div_rem_s, div_quo_s, quo_fix_s, final_s, mag1_s, mag2_s;
`ifdef MULDIV_REM_EN
    logic           is_rem_q, is_rem_d, neg_rem_q, neg_rem_d;
    logic [31:0]    rem_fix_s;
`endif

    assign is_rem_cmd_s = (EXE_CMD == REM_CMD);
`ifdef MULDIV_REM_EN
    assign is_md_s = (EXE_CMD == MUL_CMD) || (EXE_CMD == DIV_CMD) || is_rem_cmd_s;
`else
    assign is_md_s = ((EXE_CMD == MUL_CMD) || (EXE_CMD == DIV_CMD)) && !is_rem_cmd_s;
`endif

    assign stall  = !rst && (((state_q == IDLE) && start && is_md_s) || (state_q == CALC));
    assign done   = done_q;
    assign result = result_q;
    assign dest   = dest_q;
    assign WB_EN  = wb_en_q;

    // One shift-add step and one restoring-division step, plus sign fix-up of the final values
    always_comb begin
        mag1_s    = val1[31] ? (32'd0 - val1) : val1;
        mag2_s    = val2[31] ? (32'd0 - val2) : val2;
        mul_acc_s = acc_q + (b_q[0] ? a_q : 32'd0);
        rem_sh_s  = {acc_q, b_q[31]};
        div_ge_s  = (rem_sh_s >= {1'b0, a_q});
        div_rem_s = div_ge_s ? (rem_sh_s[31:0] - a_q) : rem_sh_s[31:0];
        div_quo_s = {b_q[30:0], div_ge_s};
        quo_fix_s = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (32'd0 - div_quo_s) : div_quo_s);
`ifdef MULDIV_REM_EN
        rem_fix_s = neg_rem_q ? (32'd0 - div_rem_s) : div_rem_s;
        if (is_mul_q) begin
            final_s = mul_acc_s;
        end else if (is_rem_q) begin
            final_s = rem_fix_s;
        end else begin
            final_s = quo_fix_s;
        end
`else
        if (is_mul_q) begin
            final_s = mul_acc_s;
        end else begin
            final_s = quo_fix_s;
        end
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        is_mul_d    = is_mul_q;
        neg_quo_d   = neg_quo_q;
        div_zero_d  = div_zero_q;
        dest_hold_d = dest_hold_q;
        wb_hold_d   = wb_hold_q;
        result_d    = result_q;
        dest_d      = dest_q;
        wb_en_d     = wb_en_q;
        done_d      = 1'b0;
`ifdef MULDIV_REM_EN
        is_rem_d    = is_rem_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && is_md_s) begin
                    is_mul_d    = (EXE_CMD == MUL_CMD);
                    a_d         = (EXE_CMD == MUL_CMD) ? val1 : mag2_s;
                    b_d         = (EXE_CMD == MUL_CMD) ? val2 : mag1_s;
                    acc_d       = 32'd0;
                    neg_quo_d   = val1[31] ^ val2[31];
                    div_zero_d  = (val2 == 32'd0);
                    dest_hold_d = destIn;
                    wb_hold_d   = WB_EN_IN;
                    cnt_d       = '0;
                    state_d     = CALC;
`ifdef MULDIV_REM_EN
                    is_rem_d    = is_rem_cmd_s;
                    neg_rem_d   = val1[31];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_mul_q) begin
                    acc_d = mul_acc_s;
                    a_d   = {a_q[30:0], 1'b0};
                    b_d   = {1'b0, b_q[31:1]};
                end else begin
                    acc_d = div_rem_s;
                    b_d   = div_quo_s;
                end
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = final_s;
                    dest_d   = dest_hold_q;
                    wb_en_d  = wb_hold_q;
                end else begin
                    state_d = CALC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            acc_q       <= 32'd0;
            is_mul_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            dest_hold_q <= 5'd0;
            wb_hold_q   <= 1'b0;
            result_q    <= 32'd0;
            dest_q      <= 5'd0;
            wb_en_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef MULDIV_REM_EN
            is_rem_q    <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            is_mul_q    <= is_mul_d;
            neg_quo_q   <= neg_quo_d;
            div_zero_q  <= div_zero_d;
            dest_hold_q <= dest_hold_d;
            wb_hold_q   <= wb_hold_d;
            result_q    <= result_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            done_q      <= done_d;
`ifdef MULDIV_REM_EN
            is_rem_q    <= is_rem_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed cases plus randomized operations against an arithmetic model.
module tb_exe_muldiv_unit;
    localparam logic [3:0] MUL = 4'd11;
    localparam logic [3:0] DIV = 4'd12;
    localparam logic [3:0] REM = 4'd13;

    logic        clk, rst, start, WB_EN_IN, stall, done, WB_EN;
    logic [3:0]  EXE_CMD;
    logic [31:0] val1, val2, result;
    logic [4:0]  destIn, dest;
    int          n_cmp, n_bad;

    exe_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2),
        .destIn(destIn), .WB_EN_IN(WB_EN_IN), .stall(stall), .done(done), .result(result),
        .dest(dest), .WB_EN(WB_EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: 64-bit product, native signed division with the corner cases spelled out
    function automatic logic [31:0] ref_md(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (cmd == MUL) begin
            p = 64'(a) * 64'(b);
            return p[31:0];
        end else if (cmd == DIV) begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
        end else begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
        end
    endfunction

    // Issue one md instruction in the next cycle, hold it while stalled, check timing and result
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic w, input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        start = 1'b1; EXE_CMD = cmd; val1 = a; val2 = b; destIn = d; WB_EN_IN = w;
        #1;
        check({tag, " stall c0"}, {31'd0, stall}, 32'd1);
        check({tag, " done c0"}, {31'd0, done}, 32'd0);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #2;
            check($sformatf("%s stall c%0d", tag, c), {31'd0, stall}, 32'd1);
            check($sformatf("%s done c%0d", tag, c), {31'd0, done}, 32'd0);
        end
        @(posedge clk); #2;
        check({tag, " done c33"}, {31'd0, done}, 32'd1);
        check({tag, " stall c33"}, {31'd0, stall}, 32'd0);
        check({tag, " result"}, result, exp);
        check({tag, " dest"}, {27'd0, dest}, {27'd0, d});
        check({tag, " wb_en"}, {31'd0, WB_EN}, {31'd0, w});
        start = 1'b0;
    endtask

    // Present a command that must not engage the unit for several cycles
    task automatic idle_cmd(input logic [3:0] cmd, input string tag);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b1; EXE_CMD = cmd; val1 = 32'd5; val2 = 32'd3;
            #1;
            check($sformatf("%s stall %0d", tag, c), {31'd0, stall}, 32'd0);
            check($sformatf("%s done %0d", tag, c), {31'd0, done}, 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        logic [4:0]  rd;
        logic        rw;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; EXE_CMD = 4'd0; val1 = 32'd0; val2 = 32'd0; destIn = 5'd0; WB_EN_IN = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst dest", {27'd0, dest}, 32'd0);
        check("rst wb_en", {31'd0, WB_EN}, 32'd0);
        start = 1'b1; EXE_CMD = MUL; #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        start = 1'b0; rst = 1'b0;

        run_op(MUL, 32'd7, 32'd6, 5'd3, 1'b1, 32'd42, "mul7x6");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 32'hFFFF_FFFD, "div-7/2");
        run_op(DIV, 32'd100, 32'd0, 5'd5, 1'b0, 32'hFFFF_FFFF, "div100/0");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h8000_0000, "divovf");
        run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'd1, "mulneg");

        // Abort a divide with reset in its cycle 10
        @(posedge clk); #1;
        start = 1'b1; EXE_CMD = DIV; val1 = 32'd1000; val2 = 32'd7; destIn = 5'd9; WB_EN_IN = 1'b1;
        for (int c = 1; c <= 9; c++) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("abort stall in rst", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; #1;
        check("abort stall", {31'd0, stall}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort dest", {27'd0, dest}, 32'd0);
        check("abort wb_en", {31'd0, WB_EN}, 32'd0);
        run_op(MUL, 32'd3, 32'd5, 5'd10, 1'b1, 32'd15, "mul3x5");

        idle_cmd(4'd0, "add");
`ifdef MULDIV_REM_EN
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b1, 32'hFFFF_FFFF, "rem-7,2");
        run_op(REM, 32'd9, 32'd0, 5'd12, 1'b1, 32'd9, "rem9,0");
`else
        idle_cmd(REM, "rem-off");
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef MULDIV_REM_EN
            rc = 4'd11 + 4'($urandom_range(0, 2));
`else
            rc = 4'd11 + 4'($urandom_range(0, 1));
`endif
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'($urandom_range(0, 255)) - 32'd128;
                default: ;
            endcase
            rd = 5'($urandom);
            rw = 1'($urandom);
            run_op(rc, ra, rb, rd, rw, ref_md(rc, ra, rb), $sformatf("rnd%0d cmd%0d", i, rc));
        end

        @(posedge clk); #2;
        check("final done low", {31'd0, done}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EXE stage. Consumes the operands, command, destination and write-back enable held in the ID/EXE pipeline register.
- Drives `stall` back to the hazard/freeze logic so PC, IF/ID and ID/EXE hold while the operation runs.
- Presents the result, destination and write-back enable toward EXE/MEM for one cycle when finished.
- Single-cycle ALU commands pass untouched: no stall, no result.

Parameters:
- MUL_CMD, 4'd11, EXE_CMD code for low-32-bit multiply
- DIV_CMD, 4'd12, EXE_CMD code for signed 32-bit divide (quotient)
- REM_CMD, 4'd13, EXE_CMD code for signed remainder (only with MULDIV_REM_EN)
- ITER, 32, iteration cycles per operation; fixed, must equal the operand width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  ID/EXE entry valid; held stable by the pipeline while stall=1
- EXE_CMD  in  4  command from ID/EXE
- val1  in  32  operand A / dividend
- val2  in  32  operand B / divisor
- destIn  in  5  destination register
- WB_EN_IN  in  1  write-back enable of the instruction
- stall  out  1  freeze request to the pipeline
- done  out  1  one-cycle result-valid strobe
- result  out  32  product, quotient or remainder
- dest  out  5  registered destination, valid with done
- WB_EN  out  1  registered write-back enable, valid with done

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: state=IDLE; result=0, dest=0, WB_EN=0, done=0, counter=0. stall=0 while rst=1.
- States: IDLE, CALC, DONE.
- is_md: EXE_CMD equals MUL_CMD or DIV_CMD (plus REM_CMD if enabled).
- IDLE:
  - On start && is_md, latch operands, cmd, destIn and WB_EN_IN; init the datapath; counter=0; go to CALC.
  - Otherwise stay in IDLE; done=0.
- CALC: one iteration per cycle. counter increments; at counter==ITER-1, go to DONE.
- DONE: done=1, result/dest/WB_EN valid; go to IDLE unconditionally. start is ignored (same held instruction).
- stall (combinational): (state==IDLE && start && is_md && !rst) || state==CALC. stall=0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Timing: accept cycle = cycle 0, CALC = cycles 1..32, done in cycle 33. stall is high cycles 0..32. start is ignored in CALC.
- Multiply:
  - Shift-add on a 32-bit unsigned view.
  - Result is the low 32 bits of the product; it is sign-agnostic.
- Divide:
  - Restoring division on magnitudes |val1| and |val2| (32-bit unsigned).
  - Quotient is negated if the operand signs differ.
  - val2==0: quotient=32'hFFFFFFFF.
  - 32'h80000000 / -1 = 32'h80000000 (wraps, no trap).
- Non-md command with start=1: no state change, stall=0, done=0.
- Reset mid-operation: abort next edge to IDLE, outputs cleared, no done pulse. A start in the cycle after reset is accepted normally.
- Back-to-back md instructions: the second is accepted in the IDLE cycle after DONE. No bubble is added beyond that cycle.
- Outputs result/dest/WB_EN hold their last values after done; downstream uses done as qualifier.

Optional Feature:
- Macro: MULDIV_REM_EN.
- Defined:
  - REM_CMD is an md command; result is the signed remainder, sign follows the dividend.
  - val2==0 gives remainder = val1.
  - 32'h80000000 rem -1 = 0.
  - Same latency as divide.
- Undefined:
  - REM_CMD is treated as non-md: no stall, no done.
  - No remainder sign-fix logic is synthesized.

Test Plan:
- MUL 7*6, start held while stall: stall high cycles 0..32, done=1 in cycle 33 with result=42, dest/WB_EN as issued, stall=0 in cycle 33.
- DIV -7/2 (32'hFFFFFFF9, 2) -> result 32'hFFFFFFFD. Then DIV 100/0 -> 32'hFFFFFFFF. Then 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000.
- MUL 32'hFFFFFFFF * 32'hFFFFFFFF -> 32'h00000001. Accepted in the IDLE cycle right after the previous DONE; done exactly 33 cycles later.
- rst pulsed in cycle 10 of a DIV: stall=0 next cycle, no done, outputs 0. New MUL 3*5 then completes with 15 after 33 cycles.
- EXE_CMD=4'd0 (ADD) with start=1 for 5 cycles -> stall=0 and done=0 throughout.
- With MULDIV_REM_EN: REM -7,2 -> 32'hFFFFFFFF; REM 9,0 -> 9. Without it: REM_CMD gives no stall and no done.
